tx_link_ctrl_multi: RTL

Parametrised JESD204B transmit link controller for `LANES` lanes. It runs entirely on the character clock and tracks octet, frame and multiframe (LMFC) positions with internal counters instead of derived frame and LMFC clocks. It decodes SYNC~ and sequences CGS → ILAS → DATA, driving a per-lane link-layer mux select for each lane's TX link layer. It replaces the fixed-K/F, single-lane control, frame/LMFC clock generator and SYNC~ decoder trio.

---
 rtl/tx_link_ctrl_multi.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/tx_link_ctrl_multi.sv
// JESD204B transmit link controller: octet/frame/LMFC counters, SYNC~ decode and CGS/ILAS/DATA sequencing
// producing a per-lane link-layer mux select. Optional SYNC~ error reporting via TX_SYNC_ERR_REPORT_EN.
module tx_link_ctrl_multi #(
  parameter int LANES           = 4,
  parameter int SYNC_REQ_FRAMES = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           i_F,
  input  logic [4:0]           i_K,
  input  logic [7:0]           i_ila_mf,
  input  logic                 i_sync_n,
  input  logic [LANES-1:0]     i_lane_en,
  output logic [3*LANES-1:0]   o_link_mux,
  output logic                 o_frame_start,
  output logic                 o_mf_start,
  output logic [1:0]           o_state,
  output logic                 o_err_sync
);

  localparam logic [1:0] ST_CGS  = 2'd0;
  localparam logic [1:0] ST_ILAS = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  localparam logic [2:0] MUX_DATA = 3'd0;
  localparam logic [2:0] MUX_K    = 3'd1;
  localparam logic [2:0] MUX_R    = 3'd2;
  localparam logic [2:0] MUX_Q    = 3'd3;
  localparam logic [2:0] MUX_CFG  = 3'd4;
  localparam logic [2:0] MUX_A    = 3'd5;
  localparam logic [2:0] MUX_IDLE = 3'd6;

  localparam logic [2:0] REQ_THR = 3'(SYNC_REQ_FRAMES);
  localparam logic [4:0] MFO_SAT = 5'd16;

  logic [7:0]            oct_q, oct_d;
  logic [4:0]            frm_q, frm_d;
  logic [7:0]            f_q, f_d;
  logic [4:0]            k_q, k_d;
  logic                  cfg_vld_q, cfg_vld_d;
  logic [4:0]            mf_oct_q, mf_oct_d;
  logic [7:0]            ila_q, ila_d;
  logic [1:0]            state_q, state_d;
  logic [2:0]            low_q, low_d;
  logic                  sync_q, sync_d;
  logic [LANES-1:0][2:0] mux_q, mux_d;
  logic                  frame_start_q, frame_start_d;
  logic                  mf_start_q, mf_start_d;

  logic [7:0] f_eff;
  logic [4:0] k_eff;
  logic       oct_last, mf_last, frame_pos, mf_pos, sync_req;
  logic [2:0] lane_code;

  // Counters free-run regardless of state; F/K take effect only at a multiframe wrap.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    f_eff     = cfg_vld_q ? f_q : i_F;
    k_eff     = cfg_vld_q ? k_q : i_K;
    oct_last  = (oct_q == f_eff);
    mf_last   = oct_last && (frm_q == k_eff);
    frame_pos = (oct_q == 8'd0);
    mf_pos    = frame_pos && (frm_q == 5'd0);

    oct_d = oct_last ? 8'd0 : oct_q + 8'd1;
    frm_d = frm_q;
    if (oct_last) frm_d = (frm_q == k_eff) ? 5'd0 : frm_q + 5'd1;

    f_d       = f_q;
    k_d       = k_q;
    cfg_vld_d = 1'b1;
    if (mf_last || !cfg_vld_q) begin
      f_d = i_F;
      k_d = i_K;
    end

    if (mf_last)                  mf_oct_d = 5'd0;
    else if (mf_oct_q == MFO_SAT) mf_oct_d = mf_oct_q;
    else                          mf_oct_d = mf_oct_q + 5'd1;

    frame_start_d = frame_pos;
    mf_start_d    = mf_pos;
    sync_d        = i_sync_n;
  end

  // Sequencing; a pending sync request overrides any boundary-driven transition.
  always_comb begin
    sync_req = (state_q != ST_CGS) && (low_q >= REQ_THR);
    state_d  = state_q;
    ila_d    = ila_q;
    case (state_q)
      ST_CGS: begin
        if (mf_pos && sync_q) begin
          state_d = ST_ILAS;
          ila_d   = 8'd0;
        end
      end
      ST_ILAS: begin
        if (mf_pos) begin
          if (ila_q == i_ila_mf) state_d = ST_DATA;
          else                   ila_d   = ila_q + 8'd1;
        end
      end
      ST_DATA: ;
      default: state_d = ST_CGS;
    endcase
    if (sync_req) state_d = ST_CGS;

    low_d = low_q;
    if ((state_q == ST_CGS) || sync_q || sync_req) low_d = 3'd0;
    else if (frame_pos && (low_q != 3'd7))          low_d = low_q + 3'd1;
  end

  // The mux follows the next state so a transition and its first symbol leave the register together.
  always_comb begin
    lane_code = MUX_K;
    if (state_d == ST_DATA)                          lane_code = MUX_DATA;
    else if (state_d == ST_ILAS) begin
      if (mf_pos)                                    lane_code = MUX_R;
      else if (mf_last)                              lane_code = MUX_A;
      else if ((ila_d == 8'd1) && (mf_oct_q == 5'd1)) lane_code = MUX_Q;
      else if ((ila_d == 8'd1) && (mf_oct_q >= 5'd2) && (mf_oct_q <= 5'd15))
                                                     lane_code = MUX_CFG;
      else                                           lane_code = MUX_DATA;
    end
    for (int n = 0; n < LANES; n++) mux_d[n] = i_lane_en[n] ? lane_code : MUX_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments only, so flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oct_q         <= 8'd0;
      frm_q         <= 5'd0;
      f_q           <= 8'd0;
      k_q           <= 5'd0;
      cfg_vld_q     <= 1'b0;
      mf_oct_q      <= 5'd0;
      ila_q         <= 8'd0;
      state_q       <= ST_CGS;
      low_q         <= 3'd0;
      sync_q        <= 1'b0;
      mux_q         <= {LANES{MUX_K}};
      frame_start_q <= 1'b0;
      mf_start_q    <= 1'b0;
    end else begin
      oct_q         <= oct_d;
      frm_q         <= frm_d;
      f_q           <= f_d;
      k_q           <= k_d;
      cfg_vld_q     <= cfg_vld_d;
      mf_oct_q      <= mf_oct_d;
      ila_q         <= ila_d;
      state_q       <= state_d;
      low_q         <= low_d;
      sync_q        <= sync_d;
      mux_q         <= mux_d;
      frame_start_q <= frame_start_d;
      mf_start_q    <= mf_start_d;
    end
  end

  assign o_link_mux    = mux_q;
  assign o_frame_start = frame_start_q;
  assign o_mf_start    = mf_start_q;
  assign o_state       = state_q;

`ifdef TX_SYNC_ERR_REPORT_EN
  // A SYNC~ low period ending while still in DATA never reached the request threshold.
  logic sync_prev_q, sync_prev_d;
  logic err_q, err_d;

  always_comb begin
    sync_prev_d = sync_q;
    err_d       = (state_q == ST_DATA) && sync_q && !sync_prev_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_prev_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      sync_prev_q <= sync_prev_d;
      err_q       <= err_d;
    end
  end

  assign o_err_sync = err_q;
`else
  assign o_err_sync = 1'b0;
`endif

endmodule
